// File: rtl/layer_pkg.sv
// ----------------------------------------------------------------------------
// layer_pkg
// Shared constants, field types and the sequencer state encoding for the
// clocked-STDP layer and its sample-level controller.
//   NUM_SPIKES      : input lines per volley
//   TESTING_PERIOD  : inference window length in cycles
//   TIME_PERIOD     : full sample length (inference + STDP window)
//   LOG_TIME_PERIOD : time fields are LOG_TIME_PERIOD+1 bits (MSB = no spike)
//   LOG_NEURONS     : winner field is LOG_NEURONS+1 bits
// ----------------------------------------------------------------------------
package layer_pkg;
    localparam int NUM_SPIKES      = 8;
    localparam int TESTING_PERIOD  = 8;
    localparam int TIME_PERIOD     = 16;
    localparam int LOG_TIME_PERIOD = 4;
    localparam int LOG_NEURONS     = 4;

    typedef logic [LOG_TIME_PERIOD:0] time_t;
    typedef logic [LOG_NEURONS:0]     neuron_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TEST  = 2'd1,
        TRAIN = 2'd2
    } seq_state_e;
endpackage

// File: rtl/layer_sequencer_result_slot.sv
// ----------------------------------------------------------------------------
// result_slot
// Single-entry holding register with a valid/ready output side.
//   clk, rst_l : clock, asynchronous active-low reset
//   load_i     : capture data_i this edge (sets valid_o)
//   data_i     : value to capture
//   valid_o    : slot holds a result
//   ready_i    : consumer takes the result when valid_o && ready_i
//   data_o     : held result (RESET_VAL out of reset)
// Handshake: a transfer happens on each rising edge where valid_o && ready_i;
// valid_o stays high and data_o stable until that edge. A load wins over a
// drain in the same cycle.
// ----------------------------------------------------------------------------
module result_slot #(
    parameter int           W         = 11,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/layer_sequencer.sv
// ----------------------------------------------------------------------------
// layer_sequencer
// Sample-level controller for one clocked-STDP layer. Accepts one input volley
// per sample, sweeps time_val through the test window (and the STDP window for
// training samples), captures the layer's winner/output time at the end of
// the test window and presents it on a result handshake. Between samples the
// layer is parked at time_val = TIME_PERIOD-1 with training off.
// Ports:
//   clk, rst_l                     : clock, asynchronous active-low reset
//   in_valid/in_ready              : volley handshake (accept in IDLE only)
//   in_spike_times, in_train       : volley and sample mode (1 = train)
//   layer_time_val, layer_training : sweep and training flag to the layer
//   layer_spike_times              : volley held from accept to next accept
//   layer_out_time, layer_winner   : layer results, sampled at end of test
//   res_valid/res_ready            : result handshake
//   res_time, res_winner, res_trained : captured result and its sample mode
//   sample_count                   : completed samples (wrapping)
//   busy                           : state != IDLE
//   state_dbg                      : current FSM state
// Handshakes: a transfer occurs on each rising edge where valid && ready; the
// producer holds valid and data stable until that edge.
// ----------------------------------------------------------------------------
module layer_sequencer
    import layer_pkg::*;
#(
    parameter int NUM_SPIKES      = layer_pkg::NUM_SPIKES,
    parameter int TESTING_PERIOD  = layer_pkg::TESTING_PERIOD,
    parameter int TIME_PERIOD     = layer_pkg::TIME_PERIOD,
    parameter int LOG_TIME_PERIOD = layer_pkg::LOG_TIME_PERIOD,
    parameter int LOG_NEURONS     = layer_pkg::LOG_NEURONS
) (
    input  logic                                    clk,
    input  logic                                    rst_l,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [NUM_SPIKES*(LOG_TIME_PERIOD+1)-1:0] in_spike_times,
    input  logic                                    in_train,
    output logic [LOG_TIME_PERIOD:0]                layer_time_val,
    output logic                                    layer_training,
    output logic [NUM_SPIKES*(LOG_TIME_PERIOD+1)-1:0] layer_spike_times,
    input  logic [LOG_TIME_PERIOD:0]                layer_out_time,
    input  logic [LOG_NEURONS:0]                    layer_winner,
    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [LOG_TIME_PERIOD:0]                res_time,
    output logic [LOG_NEURONS:0]                    res_winner,
    output logic                                    res_trained,
    output logic [15:0]                             sample_count,
    output logic                                    busy,
    output seq_state_e                              state_dbg
);
    localparam int TW = LOG_TIME_PERIOD + 1;
    localparam int NW = LOG_NEURONS + 1;
    localparam int SW = NUM_SPIKES * TW;
    localparam int RW = TW + NW + 1;

    localparam logic [TW-1:0] LAST_TEST = TW'(TESTING_PERIOD - 1);
    localparam logic [TW-1:0] LAST_TIME = TW'(TIME_PERIOD - 1);

    generate
        if (TIME_PERIOD != TESTING_PERIOD + NUM_SPIKES) begin : g_bad_period
            $error("layer_sequencer: TIME_PERIOD must equal TESTING_PERIOD + NUM_SPIKES");
        end
    endgenerate

    seq_state_e      state_q;
    logic [TW-1:0]   time_val_q;
    logic            training_q;
    logic            mode_q;
    logic [SW-1:0]   spikes_q;
    logic [15:0]     count_q;

    logic            accept;
    logic            capture;
    logic [RW-1:0]   res_data;

    // A held result only blocks new volleys; a draining one can overlap the
    // accept because the next capture is TESTING_PERIOD cycles away.
    assign in_ready = (state_q == IDLE) && (!res_valid || res_ready);
    assign accept   = in_valid && in_ready;
    assign capture  = (state_q == TEST) && (time_val_q == LAST_TEST);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            time_val_q <= LAST_TIME;
            training_q <= 1'b0;
            mode_q     <= 1'b0;
            spikes_q   <= '1;
            count_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= TEST;
                        time_val_q <= '0;
                        training_q <= in_train;
                        mode_q     <= in_train;
                        spikes_q   <= in_spike_times;
                    end
                end
                TEST: begin
                    if (time_val_q == LAST_TEST) begin
                        if (mode_q) begin
                            state_q    <= TRAIN;
                            time_val_q <= time_val_q + 1'b1;
                        end else begin
                            state_q    <= IDLE;
                            time_val_q <= LAST_TIME;
                            training_q <= 1'b0;
                            count_q    <= count_q + 16'd1;
                        end
                    end else begin
                        time_val_q <= time_val_q + 1'b1;
                    end
                end
                TRAIN: begin
                    if (time_val_q == LAST_TIME) begin
                        // time_val already sits at the parking value
                        state_q    <= IDLE;
                        training_q <= 1'b0;
                        count_q    <= count_q + 16'd1;
                    end else begin
                        time_val_q <= time_val_q + 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    time_val_q <= LAST_TIME;
                    training_q <= 1'b0;
                end
            endcase
        end
    end

    result_slot #(
        .W         (RW),
        .RESET_VAL ({{TW{1'b0}}, {NW{1'b1}}, 1'b0})
    ) u_result_slot (
        .clk     (clk),
        .rst_l   (rst_l),
        .load_i  (capture),
        .data_i  ({layer_out_time, layer_winner, mode_q}),
        .valid_o (res_valid),
        .ready_i (res_ready),
        .data_o  (res_data)
    );

    assign res_time          = res_data[RW-1 -: TW];
    assign res_winner        = res_data[NW:1];
    assign res_trained       = res_data[0];
    assign layer_time_val    = time_val_q;
    assign layer_training    = training_q;
    assign layer_spike_times = spikes_q;
    assign sample_count      = count_q;
    assign busy              = (state_q != IDLE);
    assign state_dbg         = state_q;
endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;
  import layer_pkg::*;

  localparam int TW = LOG_TIME_PERIOD + 1;
  localparam int NW = LOG_NEURONS + 1;
  localparam int SW = NUM_SPIKES * TW;
  localparam int RW = TW + NW + 1;

  logic          clk;
  logic          rst_l;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] in_spike_times;
  logic          in_train;
  logic [TW-1:0] layer_time_val;
  logic          layer_training;
  logic [SW-1:0] layer_spike_times;
  logic [TW-1:0] layer_out_time;
  logic [NW-1:0] layer_winner;
  logic          res_valid;
  logic          res_ready;
  logic [TW-1:0] res_time;
  logic [NW-1:0] res_winner;
  logic          res_trained;
  logic [15:0]   sample_count;
  logic          busy;
  seq_state_e    state_dbg;

  layer_sequencer dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_spike_times    (in_spike_times),
    .in_train          (in_train),
    .layer_time_val    (layer_time_val),
    .layer_training    (layer_training),
    .layer_spike_times (layer_spike_times),
    .layer_out_time    (layer_out_time),
    .layer_winner      (layer_winner),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_time          (res_time),
    .res_winner        (res_winner),
    .res_trained       (res_trained),
    .sample_count      (sample_count),
    .busy              (busy),
    .state_dbg         (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // layer stub: the real answer only shows up at the last test step
  logic [TW-1:0] stub_time;
  logic [NW-1:0] stub_winner;
  always_comb begin
    layer_out_time = ~stub_time;
    layer_winner   = stub_winner + 1'b1;
    if (layer_time_val == TW'(TESTING_PERIOD - 1)) begin
      layer_out_time = stub_time;
      layer_winner   = stub_winner;
    end
  end

  // scoreboard
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_exp;
  int n_checks = 0;
  int n_pass   = 0;
  int exp_count = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst_l && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        check_val("res_unexpected", 1, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check_val("res_data", {res_time, res_winner, res_trained}, mon_exp);
      end
    end
  end

  task automatic check_reset(input string tag);
    check_val({tag, "_in_ready"}, in_ready, 1);
    check_val({tag, "_time_val"}, layer_time_val, TIME_PERIOD - 1);
    check_val({tag, "_training"}, layer_training, 0);
    check_val({tag, "_spikes"}, layer_spike_times, {SW{1'b1}});
    check_val({tag, "_res_valid"}, res_valid, 0);
    check_val({tag, "_res_time"}, res_time, 0);
    check_val({tag, "_res_winner"}, res_winner, {NW{1'b1}});
    check_val({tag, "_res_trained"}, res_trained, 0);
    check_val({tag, "_count"}, sample_count, 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  // Driver: called at a negedge with the DUT idle; offers one volley and
  // follows the sample cycle by cycle. abort_k > 0 pulses reset in cycle k.
  task automatic run_sample(input logic train, input int abort_k);
    int len, last;
    logic [SW-1:0] spk;
    len  = train ? TIME_PERIOD + 1 : TESTING_PERIOD + 1;
    last = train ? TIME_PERIOD : TESTING_PERIOD;
    spk  = SW'({$urandom, $urandom});
    stub_time   = TW'($urandom_range(0, 15));
    stub_winner = NW'($urandom_range(0, 31));
    in_spike_times = spk;
    in_train = train;
    in_valid = 1'b1;
    #1;
    check_val("in_ready_offer", in_ready, 1);
    if (abort_k == 0) exp_q.push_back({stub_time, stub_winner, train});
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        in_spike_times = ~spk;
        in_train = ~train;
      end
      if (k == abort_k) begin
        rst_l = 1'b0;
        #1;
        check_reset("abort");
        @(negedge clk);
        rst_l = 1'b1;
        exp_count = 0;
        return;
      end
      #1;
      check_val("time_val", layer_time_val, (k - 1 < last) ? k - 1 : TIME_PERIOD - 1);
      check_val("training", layer_training, (k - 1 < last) ? train : 1'b0);
      check_val("busy", busy, (k - 1 < last) ? 1 : 0);
      check_val("spikes_held", layer_spike_times, spk);
      if (k < TESTING_PERIOD + 1) check_val("res_valid_early", res_valid, 0);
      if (k == TESTING_PERIOD + 1) check_val("res_valid_at9", res_valid, 1);
      if (k < len) begin
        check_val("in_ready_busy", in_ready, 0);
      end else begin
        exp_count++;
        check_val("sample_count", sample_count, exp_count);
        check_val("in_ready_end", in_ready, res_ready);
      end
    end
  endtask

  initial begin
    rst_l = 1'b0;
    in_valid = 1'b0;
    in_spike_times = '0;
    in_train = 1'b0;
    res_ready = 1'b1;
    stub_time = '0;
    stub_winner = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset("rst");
    @(negedge clk);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset("idle");
    @(negedge clk);

    // single test and train samples
    run_sample(1'b0, 0);
    run_sample(1'b1, 0);

    // stalled consumer: park, then drain and accept on the same edge
    res_ready = 1'b0;
    run_sample(1'b0, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check_val("stall_in_ready", in_ready, 0);
      check_val("stall_time_val", layer_time_val, TIME_PERIOD - 1);
      check_val("stall_res_valid", res_valid, 1);
    end
    @(negedge clk);
    res_ready = 1'b1;
    run_sample(1'b0, 0);

    // back-to-back test samples, each offered as soon as the last completes
    for (int i = 0; i < 10; i++) run_sample(1'b0, 0);
    run_sample(1'b1, 0);

    // reset in the middle of a training sample (time_val = 4)
    @(negedge clk);
    #1;
    check_val("pre_abort_queue", exp_q.size(), 0);
    @(negedge clk);
    run_sample(1'b1, 5);
    repeat (2) @(negedge clk);
    #1;
    check_val("post_abort_count", sample_count, 0);
    check_val("post_abort_res_valid", res_valid, 0);
    @(negedge clk);
    run_sample(1'b0, 0);
    repeat (2) @(negedge clk);
    #3;
    check_val("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/layer_sequencer.md
# layer_sequencer

Sample-level controller for the clocked-STDP layer. It accepts one input volley per sample through a valid/ready handshake and holds the spike times stable. It generates the layer's time_val sweep and training flag, captures the winner and output spike time at the end of the test window, and presents them through a result valid/ready handshake. It sits between the input encoder / testbench stream and one layer instance, and parks the layer in a quiescent state between samples.

## Interface
Parameters:
- NUM_SPIKES, 8, number of input lines.
- TESTING_PERIOD, 8, inference window length in cycles.
- TIME_PERIOD, 16, full sample length; must equal TESTING_PERIOD + NUM_SPIKES.
- LOG_TIME_PERIOD, 4, log2(TIME_PERIOD); time fields are LOG_TIME_PERIOD+1 bits wide.
- LOG_NEURONS, 4, winning-neuron field is LOG_NEURONS+1 bits wide.

Ports:
- clk  in  1  clock.
- rst_l  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input volley offered.
- in_ready  out  1  volley accepted when in_valid && in_ready.
- in_spike_times  in  NUM_SPIKES×(LOG_TIME_PERIOD+1)  per-line spike time; MSB=1 means no spike (passed through unchanged).
- in_train  in  1  sample mode: 1 = train, 0 = test.
- layer_time_val  out  LOG_TIME_PERIOD+1  time step driven to the layer.
- layer_training  out  1  training flag to the layer.
- layer_spike_times  out  same as in_spike_times  latched volley.
- layer_out_time  in  LOG_TIME_PERIOD+1  layer output_spike_time.
- layer_winner  in  LOG_NEURONS+1  layer winning_neuron.
- res_valid  out  1  result held.
- res_ready  in  1  consumer takes the result.
- res_time  out  LOG_TIME_PERIOD+1  captured output spike time.
- res_winner  out  LOG_NEURONS+1  captured winner.
- res_trained  out  1  mode of the sample that produced the result.
- sample_count  out  16  completed samples; wraps from 0xFFFF to 0.
- busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, TEST, TRAIN.
- **IDLE**
  - Drives layer_time_val = TIME_PERIOD-1 and layer_training = 0, so the layer's outputs self-clear and its weights are frozen.
  - in_ready = !res_valid || res_ready.
- **Accept** (in_valid && in_ready):
  - Latch in_spike_times into layer_spike_times and in_train into the mode register.
  - Go to TEST with time_val = 0.
- **TEST**
  - time_val increments by 1 each cycle; layer_training = latched mode.
  - In the cycle with time_val == TESTING_PERIOD-1, capture layer_out_time, layer_winner and mode into the result registers; res_valid = 1 on the next edge.
  - Mode 0: next state IDLE. Per-sample test window is TESTING_PERIOD cycles.
  - Mode 1: next state TRAIN with time_val = TESTING_PERIOD.
- **TRAIN**
  - time_val increments by 1 each cycle through TIME_PERIOD-1, then returns to IDLE.
  - Exactly NUM_SPIKES STDP cycles per sample.
- **sample_count** increments on the edge that returns to IDLE from TEST or TRAIN.
- **Result register**
  - Cleared when res_valid && res_ready.
  - The accept rule guarantees the register is empty or draining before a new capture.
- **Same-cycle events in IDLE:** res_ready drain and new accept in one cycle are both legal.
- layer_spike_times is stable from the accept edge until the next accept.

## Timing
- Reset values: state IDLE, layer_time_val = TIME_PERIOD-1, layer_training 0, layer_spike_times all-ones (no spikes), res_valid 0, res_time 0, res_winner all-ones, res_trained 0, sample_count 0, busy 0. in_ready therefore reads 1 out of reset.
- Accept edge to time_val = 0: 1 cycle.
- Accept edge to res_valid = 1: TESTING_PERIOD+1 cycles.
- Back-to-back samples with res_ready held high:
  - test mode: one accept every TESTING_PERIOD+1 cycles;
  - train mode: one accept every TIME_PERIOD+1 cycles.
- A stalled res_ready blocks in_ready only; time_val stays parked at TIME_PERIOD-1.
- rst_l asserted mid-sample returns all state to reset values asynchronously. The partial sample is discarded and not counted.
- in_valid and in_spike_times are ignored outside IDLE.

## Structure
- Shared package layer_pkg:
  - NUM_SPIKES, TESTING_PERIOD, TIME_PERIOD, LOG_TIME_PERIOD, LOG_NEURONS;
  - typedef time_t ([LOG_TIME_PERIOD:0]), neuron_t ([LOG_NEURONS:0]);
  - state enum seq_state_e {IDLE, TEST, TRAIN}.
- Elaboration-time check: TIME_PERIOD == TESTING_PERIOD + NUM_SPIKES.
- One sub-module, result_slot: a single-entry valid/ready holding register for {res_time, res_winner, res_trained}.

## Test plan
- Reset, then idle with in_valid = 0 → in_ready = 1, layer_time_val = 15, layer_training = 0, busy = 0.
- Test sample, layer_winner stub = 3, layer_out_time = 5 at time_val 7 → time_val runs 0..7 then 15; res_valid at accept+9; res_winner = 3, res_time = 5, res_trained = 0; sample_count = 1.
- Train sample → time_val runs 0..15 with layer_training = 1 throughout; res_valid at accept+9; next in_ready at accept+17; res_trained = 1.
- res_ready held 0 after a test result → in_ready stays 0 and layer_time_val stays 15. Raise res_ready with in_valid = 1 → drain and accept on the same edge.
- Ten back-to-back test samples with res_ready = 1 → accepts exactly 9 cycles apart; sample_count = 10.
- rst_l pulsed at time_val = 4 of a train sample → all outputs at reset values; sample_count = 0; no res_valid.
